// File: rtl/lcd_pkg.sv
// lcd_pkg: shared types and per-mode geometry for the LCD pixel unpacker.
package lcd_pkg;

    typedef enum logic [2:0] {BPP1, BPP2, BPP4, BPP8, BPP16, BPP24} bpp_e;

    typedef enum logic [1:0] {IDLE, FETCH, SHIFT} state_e;

    // Modes 6 and 7 alias 24bpp: one pixel in a 32-bit container.
    function automatic logic [5:0] ppw(input logic [2:0] m);
        return (m >= 3'(BPP24)) ? 6'd1 : (6'd32 >> m);
    endfunction

    function automatic logic [5:0] pix_w(input logic [2:0] m);
        return (m >= 3'(BPP24)) ? 6'd24 : (6'd1 << m);
    endfunction

endpackage

// File: rtl/lcd_pix_extract.sv
// lcd_pix_extract: selects pixel idx out of a 32-bit word for the given depth and order.
module lcd_pix_extract
    import lcd_pkg::*;
(
    input  logic [31:0] word,
    input  logic [4:0]  idx,
    input  logic [2:0]  mode,
    input  logic        be,
    output logic [23:0] pix_data,
    output logic        last
);

    logic [9:0]  w;
    logic [9:0]  lo;
    logic [31:0] mask;
    logic [23:0] pix;

    assign w    = {4'd0, pix_w(mode)};
    // Bit position of the pixel's LSB; MSB-first order counts down from bit 31.
    assign lo   = be ? 10'd32 - ({5'd0, idx} + 10'd1) * w : {5'd0, idx} * w;
    assign mask = (32'd1 << w) - 32'd1;
    assign pix  = 24'((word >> lo) & mask);

    assign pix_data = (mode >= 3'(BPP24)) ? word[23:0] : pix;
    assign last     = 6'(idx) == ppw(mode) - 6'd1;

endmodule

// File: rtl/lcd_pixel_unpack.sv
// lcd_pixel_unpack: pops 32-bit words from the show-ahead pixel FIFO and streams
// unpacked pixels over valid/ready, plus DMA refill request and underflow flag.
module lcd_pixel_unpack
    import lcd_pkg::*;
#(
    parameter int FIFO_DEPTH = 32,
    parameter int LOW_WM     = 16
) (
    input  logic                            HCLK,
    input  logic                            HRESET,
    input  logic                            en,
    input  logic                            flush,
    input  logic [2:0]                      bpp_mode,
    input  logic                            be_pixel,
    input  logic                            fifoempty,
    input  logic [31:0]                     rdata,
    input  logic [$clog2(FIFO_DEPTH+1)-1:0] cnt,
    output logic                            pull,
    output logic                            pix_valid,
    input  logic                            pix_ready,
    output logic [23:0]                     pix_data,
    output logic                            dma_req,
    output logic                            underflow
);

    state_e      state_q;
    state_e      state_d;
    logic [31:0] word_q;
    logic [4:0]  pix_idx;
    logic [2:0]  mode_q;
    logic        be_q;
    logic        last;
    logic        hs;

    lcd_pix_extract u_extract (
        .word     (word_q),
        .idx      (pix_idx),
        .mode     (mode_q),
        .be       (be_q),
        .pix_data (pix_data),
        .last     (last)
    );

    assign pix_valid = state_q == SHIFT;
    assign hs        = pix_valid && pix_ready;
    // Reloading on the last handshake keeps one pixel per cycle even at one pixel per word.
    assign pull      = en && !flush && !HRESET && !fifoempty && (state_q == FETCH || (hs && last));

    always_comb begin
        state_d = state_q;
        if (flush || !en)
            state_d = en ? FETCH : IDLE;
        else if (state_q == IDLE)
            state_d = FETCH;
        else if (pull)
            state_d = SHIFT;
        else if (hs && last)
            state_d = FETCH;
    end

    always_ff @(posedge HCLK) begin
        state_q   <= HRESET ? IDLE : state_d;
        dma_req   <= !HRESET && en && !flush && int'(cnt) <= LOW_WM;
        underflow <= !HRESET && en && !flush && pix_ready && fifoempty && state_q == FETCH;
        if (HRESET || flush || !en) begin
            word_q  <= '0;
            pix_idx <= '0;
            mode_q  <= '0;
            be_q    <= 1'b0;
        end else if (pull) begin
            word_q  <= rdata;
            pix_idx <= '0;
            mode_q  <= bpp_mode;
            be_q    <= be_pixel;
        end else if (hs) begin
            pix_idx <= last ? 5'd0 : pix_idx + 5'd1;
        end
    end

endmodule

// File: tb/tb_lcd_pixel_unpack.sv
// tb_lcd_pixel_unpack: directed scenarios plus randomized streaming against a queue-based
// FIFO and pixel-stream reference model.
module tb_lcd_pixel_unpack;

    logic        HCLK = 1'b0;
    logic        HRESET, en, flush, be_pixel, fifoempty, pull, pix_valid, pix_ready;
    logic        dma_req, underflow;
    logic [2:0]  bpp_mode;
    logic [31:0] rdata;
    logic [5:0]  cnt;
    logic [23:0] pix_data;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cnt_ovr = -1;
    logic        do_pop;
    logic [31:0] q[$];
    logic [23:0] exp_q[$];
    logic [23:0] pex[8] = '{24'h11, 24'h22, 24'h33, 24'h44, 24'h55, 24'h66, 24'h77, 24'h88};

    lcd_pixel_unpack dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .en        (en),
        .flush     (flush),
        .bpp_mode  (bpp_mode),
        .be_pixel  (be_pixel),
        .fifoempty (fifoempty),
        .rdata     (rdata),
        .cnt       (cnt),
        .pull      (pull),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_data  (pix_data),
        .dma_req   (dma_req),
        .underflow (underflow)
    );

    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    function automatic logic [23:0] ref_pix(input logic [31:0] w, input int mode, input bit be, input int i);
        int pw, n;
        if (mode >= 5) return w[23:0];
        pw = 1 << mode;
        n  = 32 / pw;
        if (be) i = n - 1 - i;
        return 24'((64'(w) >> (i * pw)) & ((64'd1 << pw) - 64'd1));
    endfunction

    task automatic drive_fifo();
        fifoempty = q.size() == 0;
        rdata     = (q.size() > 0) ? q[0] : 32'h0;
        cnt       = (cnt_ovr >= 0) ? 6'(cnt_ovr) : 6'(q.size());
    endtask

    task automatic push(input logic [31:0] w);
        int n;
        n = (bpp_mode >= 5) ? 1 : 32 >> bpp_mode;
        q.push_back(w);
        for (int i = 0; i < n; i++) exp_q.push_back(ref_pix(w, int'(bpp_mode), be_pixel, i));
    endtask

    task automatic tick();
        do_pop = pull;
        @(posedge HCLK);
        #1;
        if (do_pop === 1'b1 && q.size() > 0) void'(q.pop_front());
        drive_fifo();
    endtask

    task automatic cyc();
        tick();
        #1;
    endtask

    task automatic restart(input logic [2:0] mode, input logic be);
        q.delete();
        exp_q.delete();
        bpp_mode = mode;
        be_pixel = be;
        flush    = 1'b1;
        drive_fifo();
        #1;
        chk("restart_pull", pull, 0);
        tick();
        flush = 1'b0;
        #1;
        chk("restart_valid", pix_valid, 0);
    endtask

    initial begin
        HRESET = 1'b1; en = 1'b0; flush = 1'b0; bpp_mode = 3'd3; be_pixel = 1'b0; pix_ready = 1'b0;
        drive_fifo();
        #1;
        cyc();
        chk("rst_valid", pix_valid, 0);
        chk("rst_data", pix_data, 0);
        chk("rst_dma", dma_req, 0);
        chk("rst_uf", underflow, 0);
        en = 1'b1; pix_ready = 1'b1;
        push(32'h44332211);
        push(32'h88776655);
        drive_fifo();
        #1;
        chk("rst_pull", pull, 0);
        tick();
        HRESET = 1'b0;
        #1;
        chk("idle_pull", pull, 0);
        cyc();
        chk("fetch_pull", pull, 1);
        cyc();
        for (int i = 0; i < 8; i++) begin
            chk("b8_valid", pix_valid, 1);
            chk("b8_data", pix_data, pex[i]);
            chk("b8_pull", pull, i == 3);
            cyc();
        end
        chk("uf_valid", pix_valid, 0);
        chk("uf_early", underflow, 0);
        cyc();
        chk("uf_pulse", underflow, 1);
        chk("uf_pull", pull, 0);
        pix_ready = 1'b0;
        #1;
        cyc();
        chk("uf_noready", underflow, 0);

        cnt_ovr = 17; drive_fifo(); #1;
        cyc();
        chk("dma_17", dma_req, 0);
        cnt_ovr = 16; drive_fifo(); #1;
        chk("dma_16_delay", dma_req, 0);
        cyc();
        chk("dma_16", dma_req, 1);
        cnt_ovr = 17; drive_fifo(); #1;
        chk("dma_17_delay", dma_req, 1);
        cyc();
        chk("dma_17b", dma_req, 0);
        cnt_ovr = 0; drive_fifo(); #1;
        cyc();
        chk("dma_0", dma_req, 1);
        cnt_ovr = 32; drive_fifo(); #1;
        cyc();
        chk("dma_32", dma_req, 0);
        cnt_ovr = -1; drive_fifo(); #1;

        restart(3'd0, 1'b1);
        pix_ready = 1'b1;
        push(32'h80000001);
        push(32'h00000000);
        drive_fifo();
        #1;
        cyc();
        for (int i = 0; i < 32; i++) begin
            chk("b1_data", pix_data, (i == 0 || i == 31) ? 1 : 0);
            chk("b1_pull", pull, i == 31);
            cyc();
        end

        restart(3'd5, 1'b0);
        pix_ready = 1'b1;
        push(32'hAA123456);
        push(32'h00ABCDEF);
        drive_fifo();
        #1;
        chk("b24_pull0", pull, 1);
        cyc();
        chk("b24_pix0", pix_data, 24'h123456);
        chk("b24_pull1", pull, 1);
        cyc();
        chk("b24_pix1", pix_data, 24'hABCDEF);
        chk("b24_valid", pix_valid, 1);

        restart(3'd4, 1'b0);
        pix_ready = 1'b0;
        push(32'hBEEFCAFE);
        drive_fifo();
        #1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("stall_valid", pix_valid, 1);
            chk("stall_data", pix_data, 24'h00CAFE);
        end
        pix_ready = 1'b1;
        #1;
        chk("stall_rel", pix_data, 24'h00CAFE);
        cyc();
        chk("b16_hi", pix_data, 24'h00BEEF);

        restart(3'd3, 1'b0);
        pix_ready = 1'b1;
        push(32'h44332211);
        push(32'h01020304);
        drive_fifo();
        #1;
        cyc(); cyc(); cyc();
        chk("fl_idx2", pix_data, 24'h33);
        chk("fl_dma_pre", dma_req, 1);
        flush = 1'b1;
        #1;
        chk("fl_pull", pull, 0);
        tick();
        flush = 1'b0;
        #1;
        chk("fl_valid", pix_valid, 0);
        chk("fl_dma", dma_req, 0);
        chk("fl_uf", underflow, 0);
        chk("fl_data", pix_data, 0);
        chk("fl_refetch", pull, 1);
        cyc();
        chk("fl_next", pix_data, 24'h04);
        cyc(); cyc(); cyc();
        chk("en_last", pix_data, 24'h01);
        push(32'h0A0B0C0D);
        drive_fifo();
        en = 1'b0;
        #1;
        chk("en_pull", pull, 0);
        cyc();
        chk("en_valid", pix_valid, 0);
        chk("en_data", pix_data, 0);
        chk("en_idle_pull", pull, 0);
        en = 1'b1;
        #1;
        chk("en_rise_pull", pull, 0);
        cyc();
        chk("en_fetch_pull", pull, 1);
        cyc();
        chk("en_kept", pix_data, 24'h0D);
        cyc();
        HRESET = 1'b1;
        #1;
        chk("hr_pull", pull, 0);
        tick();
        #1;
        chk("hr_valid", pix_valid, 0);
        chk("hr_data", pix_data, 0);
        chk("hr_dma", dma_req, 0);
        chk("hr_uf", underflow, 0);
        HRESET = 1'b0;

        for (int m = 0; m < 8; m++) begin
            restart(3'(m), 1'($urandom_range(0, 1)));
            for (int c = 0; c < 300; c++) begin
                tick();
                if ($urandom_range(0, 2) == 0 && q.size() < 32) push($urandom);
                drive_fifo();
                pix_ready = $urandom_range(0, 3) != 0;
                #1;
                if (pull) chk("pull_empty", fifoempty, 0);
                if (pix_valid && pix_ready) begin
                    if (exp_q.size() == 0) chk("extra_pix", 1, 0);
                    else chk("rnd_pix", pix_data, exp_q.pop_front());
                end
            end
            for (int c = 0; c < 1500 && exp_q.size() > 0; c++) begin
                tick();
                pix_ready = 1'b1;
                #1;
                if (pix_valid) chk("drain_pix", pix_data, exp_q.pop_front());
            end
            chk("drain_left", exp_q.size(), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/lcd_pixel_unpack.md
Name: lcd_pixel_unpack

Overview:
Read side of the LCD pixel FIFO. Pulls 32-bit words from the show-ahead FIFO (rdata is valid whenever fifoempty=0) and unpacks each word into pixels according to the bits-per-pixel mode. Emits the pixels one at a time to the panel timing/palette stage over a valid/ready handshake. Generates the DMA refill request from the FIFO fill count and flags underflow.

Parameters:
FIFO_DEPTH, 32, FIFO word capacity; cnt range is 0..FIFO_DEPTH.
LOW_WM, 16, dma_req asserts when cnt <= LOW_WM.

Ports:
HCLK  in  1  clock
HRESET  in  1  reset, synchronous, active-high
en  in  1  LCD enable; 0 idles the block and discards any held word
flush  in  1  same flush strobe the FIFO receives; clears all state
bpp_mode  in  3  0=1bpp 1=2bpp 2=4bpp 3=8bpp 4=16bpp 5=24bpp in 32-bit container; 6,7 treated as 5
be_pixel  in  1  1: pixel 0 in MSBs of word; 0: pixel 0 in LSBs
fifoempty  in  1  FIFO empty
rdata  in  32  FIFO head word
cnt  in  6  FIFO fill count
pull  out  1  FIFO pop, combinational, one cycle per word
pix_valid  out  1  pixel available
pix_ready  in  1  downstream accepts pixel
pix_data  out  24  pixel, zero-extended raw bits (24bpp: word[23:0])
dma_req  out  1  refill request to DMA, registered
underflow  out  1  one-cycle pulse, registered

Behaviour:
- Reset (HRESET=1 at HCLK edge): word_q=0, pix_idx=0, mode_q=0, be_q=0, pix_valid=0, dma_req=0, underflow=0. pull=0 while HRESET=1. pix_data=0 because word_q=0.
- Pixels per word: 32/16/8/4/2/1 for modes 0..5. Word width is 32; pix_idx is 5 bits and wraps at PPW-1.
- Extraction, with W = pixel width: LSB order gives pixel i = word_q[i*W +: W]. MSB order gives pixel i = word_q[31-i*W -: W]. Mode 5 ignores order and outputs word_q[23:0].
- pix_data is a pure function of registered word_q, pix_idx, mode_q and be_q, so it is stable while pix_valid=1 and pix_ready=0.
- States:
  - IDLE: en=0.
  - FETCH: no held word; pix_valid=0.
  - SHIFT: word held; pix_valid=1.
- IDLE: en=1 moves to FETCH next cycle.
- FETCH: if fifoempty=0 then pull=1 the same cycle; word_q<=rdata, mode_q<=bpp_mode, be_q<=be_pixel, pix_idx<=0, go to SHIFT. pix_valid=1 on the cycle after pull, so latency is 1 cycle.
- SHIFT, handshake when pix_valid && pix_ready:
  - Not the last pixel: pix_idx++.
  - Last pixel and fifoempty=0: pull=1 and reload in the same cycle, with no bubble. This sustains 1 pixel/cycle in every mode, including 24bpp.
  - Last pixel and fifoempty=1: go to FETCH.
- mode and order are sampled only at word load. A bpp_mode change mid-word takes effect on the next word.
- underflow pulses for 1 cycle when en=1, flush=0, pix_ready=1, FIFO empty and no pixel is available (FETCH with fifoempty=1, or SHIFT last pixel accepted with fifoempty=1 in the prior cycle and still empty). It does not pulse in IDLE.
- dma_req <= en && !flush && (cnt <= LOW_WM), registered one cycle. cnt=LOW_WM asserts; cnt=LOW_WM+1 deasserts.
- flush=1: priority over everything.
  - pull=0 that cycle.
  - Next cycle: pix_valid=0, pix_idx=0, word_q=0, dma_req=0, underflow=0.
  - State becomes FETCH if en=1, else IDLE.
- en falls mid-word: pull=0 from that cycle; next cycle pix_valid=0 and the held word is discarded, with state IDLE. The FIFO content is kept.
- pull is never asserted when fifoempty=1, flush=1, en=0 or HRESET=1.

Decomposition:
- lcd_pkg holds: typedef enum logic [2:0] bpp_e (BPP1..BPP24); constant arrays or functions for pixels-per-word and pixel width per mode; typedef state_e {IDLE,FETCH,SHIFT}.
- One combinational sub-module, lcd_pix_extract (word, idx, mode, be -> pix_data, last), holds the mux.
- The FSM, handshake and dma_req stay in the top.

Test Plan:
- 8bpp, be_pixel=0, FIFO holds 0x44332211, pix_ready=1 -> pull one cycle; pix_data 0x11,0x22,0x33,0x44 on 4 consecutive cycles; pull again at the 0x44 handshake if non-empty.
- 1bpp, be_pixel=1, word 0x80000001 -> pixel 0 = 1, pixels 1..30 = 0, pixel 31 = 1; 32 handshakes per pull.
- 24bpp, FIFO words 0xAA123456 then 0x00ABCDEF, pix_ready=1 -> pix_data 0x123456 then 0xABCDEF on back-to-back cycles; pull high two consecutive cycles.
- 16bpp word 0xBEEFCAFE, pix_ready low 3 cycles after pix_valid -> pix_data held at 0xCAFE throughout; after ready, 0xBEEF.
- FIFO empty, en=1, pix_ready=1 -> underflow pulses; pull=0. cnt sweep 17->16->17 with LOW_WM=16 -> dma_req 0,1,0, each one cycle delayed.
- Mid-word (8bpp, idx=2) flush=1 -> pull=0 that cycle; next cycle pix_valid=0, dma_req=0. Repeat with en dropped instead -> state IDLE, no pull. Synchronous HRESET mid-word -> all outputs 0 the following cycle.
